// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: scan-result encodings,
// key index mapping and the event record handed to the voice/mode logic.
package keypad_pkg;

    // Bit 4 set marks a non-index result; bits 3:0 carry the switch index otherwise.
    typedef logic [4:0] key_t;

    localparam key_t       KEY_NONE     = 5'h10;
    localparam key_t       KEY_INVALID  = 5'h11;
    localparam logic [3:0] MODE_IDX     = 4'd15;
    localparam logic [3:0] UNUSED_IDX_A = 4'd13;
    localparam logic [3:0] UNUSED_IDX_B = 4'd14;
    localparam logic [3:0] LAST_NOTE    = 4'd12;

    typedef struct packed {
        logic       press;
        logic [3:0] keycode;
        logic       modekey;
    } evt_t;

    function automatic logic [3:0] key_keycode(key_t k);
        if (!k[4] && k[3:0] <= LAST_NOTE) begin
            return k[3:0] + 4'd1;
        end
        return 4'd0;
    endfunction

    function automatic logic key_is_mode(key_t k);
        return k == {1'b0, MODE_IDX};
    endfunction

    function automatic logic key_present(key_t k);
        return (key_keycode(k) != 4'd0) || key_is_mode(k);
    endfunction

    function automatic evt_t make_evt(logic press, key_t k);
        evt_t e;
        e.press   = press;
        e.keycode = key_keycode(k);
        e.modekey = key_is_mode(k);
        return e;
    endfunction

    // Unused switch positions collapse to NONE so they never disturb the stable key.
    function automatic key_t scan_to_key(logic [15:0] bits);
        int         ones = 0;
        logic [3:0] idx  = 4'd0;
        for (int i = 0; i < 16; i++) begin
            if (bits[i]) begin
                ones++;
                idx = 4'(i);
            end
        end
        if (ones == 0) return KEY_NONE;
        if (ones > 1) return KEY_INVALID;
        if (idx == UNUSED_IDX_A || idx == UNUSED_IDX_B) return KEY_NONE;
        return {1'b0, idx};
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Press/release event channel from the keypad scanner to the voice/mode logic.
interface keypad_scanner_if;

    logic       evt_valid;
    logic       evt_ready;
    logic       evt_press;
    logic [3:0] evt_keycode;
    logic       evt_modekey;

    modport master (
        output evt_valid,
        output evt_press,
        output evt_keycode,
        output evt_modekey,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_press,
        input  evt_keycode,
        input  evt_modekey,
        output evt_ready
    );

endinterface

// File: rtl/keypad_debounce.sv
// Debounces full-scan results into a stable key state and flags each accepted
// change for exactly one cycle, alongside the state being left and entered.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic i_scan_end,
    input  key_t i_result,
    output logic o_change,
    output key_t o_old,
    output key_t o_new,
    output key_t o_stable
);

    localparam logic [3:0] MATCH_TARGET = 4'(DEBOUNCE_SCANS);

    key_t       r_prev;
    key_t       r_stable;
    logic [3:0] r_count;
    logic [3:0] w_count_next;
    logic       w_valid;

    // NOTE: every variable in a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_valid      = (i_result != KEY_INVALID);
        w_count_next = r_count;
        if (!w_valid) begin
            w_count_next = 4'd0;
        end else if (i_result == r_prev) begin
            w_count_next = (r_count == 4'hF) ? r_count : r_count + 4'd1;
        end else begin
            w_count_next = 4'd1;
        end
    end

    // The change strobe is combinational so the event can be queued on the scan-end edge itself.
    assign o_change = i_scan_end && w_valid && (w_count_next == MATCH_TARGET)
                      && (i_result != r_stable);
    assign o_old    = r_stable;
    assign o_new    = i_result;
    assign o_stable = r_stable;

    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev   <= KEY_NONE;
            r_stable <= KEY_NONE;
            r_count  <= 4'd0;
        end else if (i_scan_end) begin
            r_prev  <= i_result;
            r_count <= w_count_next;
            if (o_change) begin
                r_stable <= i_result;
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scan controller: column sequencer, row synchronizer, scan
// evaluation, debounce and a two-entry press/release event FIFO.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV       = 1000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [3:0]       row_in,
    output logic [3:0]       col_out,
    keypad_scanner_if.master evt,
    output logic [3:0]       held_keycode,
    output logic             held_modekey,
    output logic             overflow
);

    localparam logic [15:0] DIV_LAST = 16'(SCAN_DIV - 1);

    logic [3:0]  r_row_meta;
    logic [3:0]  r_row_sync;
    logic [15:0] r_div;
    logic [1:0]  r_col;
    logic [15:0] r_scan;
    logic [15:0] w_scan_now;
    logic        w_col_end;
    logic        w_scan_end;
    key_t        w_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_meta <= 4'd0;
            r_row_sync <= 4'd0;
        end else begin
            r_row_meta <= row_in;
            r_row_sync <= r_row_meta;
        end
    end

    assign w_col_end  = (r_div == DIV_LAST);
    assign w_scan_end = w_col_end && (r_col == 2'd3);
    assign col_out    = 4'b1000 >> r_col;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_div <= 16'd0;
            r_col <= 2'd0;
        end else if (w_col_end) begin
            r_div <= 16'd0;
            r_col <= r_col + 2'd1;
        end else begin
            r_div <= r_div + 16'd1;
        end
    end

    // Row pin1 sits on row_in[3]; switch (r, c) lands at bit 4r+c of the scan map.
    always_comb begin
        w_scan_now = r_scan;
        for (int r = 0; r < 4; r++) begin
            w_scan_now[{2'(r), r_col}] = r_row_sync[3 - r];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_scan <= 16'd0;
        end else if (w_col_end) begin
            r_scan <= w_scan_now;
        end
    end

    assign w_result = scan_to_key(w_scan_now);

    logic w_change;
    key_t w_old;
    key_t w_new;
    key_t w_stable;

    keypad_debounce #(
        .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
    ) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .i_scan_end(w_scan_end),
        .i_result  (w_result),
        .o_change  (w_change),
        .o_old     (w_old),
        .o_new     (w_new),
        .o_stable  (w_stable)
    );

    assign held_keycode = key_keycode(w_stable);
    assign held_modekey = key_is_mode(w_stable);

    // A direct A->B change queues the release now and parks the press for the next cycle.
    logic r_pend_valid;
    evt_t r_pend;
    logic w_push;
    evt_t w_push_evt;

    always_comb begin
        w_push     = 1'b0;
        w_push_evt = '0;
        if (r_pend_valid) begin
            w_push     = 1'b1;
            w_push_evt = r_pend;
        end else if (w_change) begin
            if (key_present(w_old)) begin
                w_push     = 1'b1;
                w_push_evt = make_evt(1'b0, w_old);
            end else if (key_present(w_new)) begin
                w_push     = 1'b1;
                w_push_evt = make_evt(1'b1, w_new);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pend_valid <= 1'b0;
            r_pend       <= '0;
        end else begin
            r_pend_valid <= w_change && key_present(w_old) && key_present(w_new);
            r_pend       <= make_evt(1'b1, w_new);
        end
    end

    evt_t       r_mem [2];
    logic       r_rd_ptr;
    logic       r_wr_ptr;
    logic [1:0] r_count;
    logic       r_overflow;
    logic       w_pop;
    logic       w_full;
    logic       w_accept;
    evt_t       w_head;

    assign evt.evt_valid = (r_count != 2'd0);
    assign w_pop         = evt.evt_valid && evt.evt_ready;
    assign w_full        = (r_count == 2'd2);
    assign w_accept      = w_push && (!w_full || w_pop);

    // NOTE: FIFO storage carries no reset; an entry is only observed while the count says it is valid.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_mem[r_wr_ptr] <= w_push_evt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_ptr   <= 1'b0;
            r_wr_ptr   <= 1'b0;
            r_count    <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept) r_wr_ptr <= ~r_wr_ptr;
            if (w_pop) r_rd_ptr <= ~r_rd_ptr;
            r_count <= r_count + {1'b0, w_accept} - {1'b0, w_pop};
            if (w_push && !w_accept) r_overflow <= 1'b1;
        end
    end

    assign w_head          = r_mem[r_rd_ptr];
    assign evt.evt_press   = evt.evt_valid && w_head.press;
    assign evt.evt_keycode = evt.evt_valid ? w_head.keycode : 4'd0;
    assign evt.evt_modekey = evt.evt_valid && w_head.modekey;
    assign overflow        = r_overflow;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a behavioural keypad matrix closes switches
// against the driven column, and each step compares outputs to hand-derived values.
module tb_keypad_scanner;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  held_keycode;
    logic        held_modekey;
    logic        overflow;
    logic [15:0] keys;
    int          checks = 0;
    int          failures = 0;
    int          evt_count = 0;

    keypad_scanner_if evt_if ();

    keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .row_in      (row_in),
        .col_out     (col_out),
        .evt         (evt_if.master),
        .held_keycode(held_keycode),
        .held_modekey(held_modekey),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Switch (r, c) connects column pin col_out[3-c] to row pin row_in[3-r].
    always_comb begin
        row_in = 4'd0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[4 * r + c] && col_out[3 - c]) row_in[3 - r] = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (evt_if.evt_valid && evt_if.evt_ready) evt_count <= evt_count + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run_scans(input int n);
        repeat (n * 16) @(negedge clk);
    endtask

    task automatic wait_col(input logic [3:0] pat);
        int n = 0;
        while (col_out !== pat && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("wait_col", 32'(col_out), 32'(pat));
    endtask

    task automatic align_scan();
        wait_col(4'b0001);
        wait_col(4'b1000);
    endtask

    // Waits for the head event, compares it, then steps one cycle so ready can pop it.
    task automatic expect_event(input string tag, input logic press, input logic [3:0] kc,
                                input logic mode);
        int n = 0;
        while (!evt_if.evt_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(evt_if.evt_valid), 32'd1);
        check(tag, 32'({evt_if.evt_press, evt_if.evt_keycode, evt_if.evt_modekey}),
              32'({press, kc, mode}));
        @(negedge clk);
    endtask

    initial begin
        int n;
        int base;

        keys             = 16'h0002;
        reset            = 1'b1;
        evt_if.evt_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_col_out", 32'(col_out), 32'h8);
        check("rst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
        check("rst_evt_fields", 32'({evt_if.evt_press, evt_if.evt_keycode, evt_if.evt_modekey}), 32'd0);
        check("rst_held", 32'({held_keycode, held_modekey}), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);

        // Single press/release, key closed across reset: second scan end is cycle 31.
        reset = 1'b0;
        n = 0;
        while (!evt_if.evt_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        check("press_latency", 32'(n), 32'd32);
        expect_event("press_kc2", 1'b1, 4'd2, 1'b0);
        check("held_kc2", 32'(held_keycode), 32'd2);
        keys = 16'h0000;
        expect_event("release_kc2", 1'b0, 4'd2, 1'b0);
        check("held_after_release", 32'(held_keycode), 32'd0);

        // Mode key, then unused index 13.
        keys = 16'h8000;
        expect_event("press_mode", 1'b1, 4'd0, 1'b1);
        check("held_mode", 32'({held_keycode, held_modekey}), 32'h01);
        keys = 16'h0000;
        expect_event("release_mode", 1'b0, 4'd0, 1'b1);
        keys = 16'h2000;
        base = evt_count;
        run_scans(6);
        check("unused_idx_no_evt", 32'(evt_count), 32'(base));
        check("unused_idx_held", 32'({held_keycode, held_modekey}), 32'd0);

        // Bounce rejection on row1/col0, toggled on alternate scans.
        keys = 16'h0000;
        run_scans(2);
        align_scan();
        base = evt_count;
        for (int s = 0; s < 6; s++) begin
            keys = (s % 2 == 0) ? 16'h0010 : 16'h0000;
            run_scans(1);
        end
        check("bounce_no_evt", 32'(evt_count), 32'(base));
        keys = 16'h0010;
        expect_event("press_kc5", 1'b1, 4'd5, 1'b0);
        keys = 16'h0000;
        expect_event("release_kc5", 1'b0, 4'd5, 1'b0);

        // Ghosting: two switches closed is not a key.
        align_scan();
        base = evt_count;
        keys = 16'h0401;
        run_scans(4);
        check("ghost_no_evt", 32'(evt_count), 32'(base));
        check("ghost_held", 32'(held_keycode), 32'd0);
        keys = 16'h0001;
        expect_event("press_kc1", 1'b1, 4'd1, 1'b0);
        keys = 16'h0000;
        expect_event("release_kc1", 1'b0, 4'd1, 1'b0);

        // Direct change under backpressure, then an overflowing third change.
        keys = 16'h0004;
        expect_event("press_kc3", 1'b1, 4'd3, 1'b0);
        evt_if.evt_ready = 1'b0;
        keys = 16'h0080;
        run_scans(6);
        check("bp_head_valid", 32'(evt_if.evt_valid), 32'd1);
        check("bp_head_release3", 32'({evt_if.evt_press, evt_if.evt_keycode, evt_if.evt_modekey}), 32'h06);
        check("bp_held_kc8", 32'(held_keycode), 32'd8);
        check("bp_no_overflow", 32'(overflow), 32'd0);
        keys = 16'h0010;
        run_scans(6);
        check("overflow_set", 32'(overflow), 32'd1);
        check("bp_head_stable", 32'({evt_if.evt_press, evt_if.evt_keycode, evt_if.evt_modekey}), 32'h06);
        check("held_kc5", 32'(held_keycode), 32'd5);
        evt_if.evt_ready = 1'b1;
        expect_event("drain_release3", 1'b0, 4'd3, 1'b0);
        expect_event("drain_press8", 1'b1, 4'd8, 1'b0);
        check("drained_empty", 32'(evt_if.evt_valid), 32'd0);

        // Reset during column 2 with a key held.
        evt_if.evt_ready = 1'b0;
        wait_col(4'b0010);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_col_out", 32'(col_out), 32'h8);
        check("midrst_held", 32'(held_keycode), 32'd0);
        check("midrst_evt_valid", 32'(evt_if.evt_valid), 32'd0);
        check("midrst_overflow", 32'(overflow), 32'd0);
        reset            = 1'b0;
        evt_if.evt_ready = 1'b1;
        expect_event("post_rst_press_kc5", 1'b1, 4'd5, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
